dsc_reg_sched: RTL and testbench
================================

# dsc_reg_sched

Double-buffered register scheduler for the DebugScreenCore display path. It owns two banks of 2^AW×DW registers and shares them between a CPU write port and the screen's register read port (`regAddr`/`regData`). The CPU only writes the shadow bank. A commit swaps banks at the next vertical-sync assertion, so every displayed frame shows one coherent register snapshot. After each swap, the block copies the new active bank back into the shadow bank so the CPU keeps editing the latest values.

## Interface
Parameters:
- `AW`, 5, register address width (bank depth 2^AW)
- `DW`, 32, register data width
- `VS_POL`, 0, vsync active level (0 = active-low)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `wr_valid`  in  1  CPU write request
- `wr_ready`  out  1  write can be accepted
- `wr_addr`  in  AW  write register index
- `wr_data`  in  DW  write data
- `commit_req`  in  1  request bank swap at next frame boundary
- `commit_busy`  out  1  commit pending or copy in progress
- `commit_done`  out  1  one-cycle pulse when copy-back finishes
- `vsync`  in  1  vsync from screen core, synchronous to `clk`
- `regAddr`  in  AW  display read index
- `regData`  out  DW  display read data from active bank
- `frame_cnt`  out  16  frame boundaries seen, wraps 0xFFFF→0

## Operation
- Banks B0/B1 and select bit `sel`: active = B[sel], shadow = B[~sel].
- Frame boundary `fb` = (vsync == VS_POL) && (vsync_d != VS_POL), where `vsync_d` is a registered copy of `vsync`. `vsync_d` resets to the inactive level.
- `frame_cnt` increments on every `fb`, in any state.
- FSM states:
  - IDLE: `wr_ready`=1. `commit_req`=1 moves to PEND.
  - PEND: `wr_ready`=1. `fb` toggles `sel`, clears copy counter `cc`, and moves to COPY.
  - COPY: `wr_ready`=0. Each cycle, shadow[cc] ← active[cc] and `cc`++. When `cc` = 2^AW−1, the block performs the last copy, moves to IDLE and pulses `commit_done`.
- `commit_busy` = (state != IDLE).
- `commit_req` in PEND or COPY is ignored. There is no queuing.
- A write is accepted when `wr_valid && wr_ready`. It updates shadow[`wr_addr`] at that clock edge.
- A write in the same cycle as the PEND `fb` goes to the old shadow, which becomes active. The write is therefore visible in the new frame.
- `commit_req` and `fb` in the same IDLE cycle: the block enters PEND and waits for the next `fb`. The swap is not taken this frame.
- A write during COPY is stalled by `wr_ready`=0. The CPU must hold `wr_valid`, `wr_addr` and `wr_data` until accepted.
- `regData` always reads active[`regAddr`]. Copy-back never alters the active bank.
- Reset, including mid-COPY or mid-PEND, asynchronously forces:
  - both banks to 0, `sel`=0, state IDLE, `cc`=0
  - `frame_cnt`=0, `commit_done`=0, `commit_busy`=0, `wr_ready`=1, `regData`=0
  - any pending commit is lost

## Timing
- Write latency: data is in the shadow bank on the edge it is accepted. It becomes display-visible only after a swap.
- `commit_req` sampled high in IDLE: `commit_busy`=1 from the next cycle.
- `fb` is detected in the cycle `vsync` first reads active. `sel` toggles on that edge, and `regData` reflects the new bank the following cycle.
- COPY lasts exactly 2^AW cycles (32 by default). `commit_done` is high in the cycle after the last copy, the same cycle state is IDLE and `wr_ready` returns to 1.
- Minimum swap latency from commit: 1 cycle to PEND, then up to one frame waiting for `fb`.
- `frame_cnt` updates on the `fb` edge.

## Configuration
- `DSC_SCHED_RDREG_EN` defined:
  - `regData` is registered, so it carries active[`regAddr`] sampled at the previous edge.
  - Read latency is 1 cycle.
  - After a swap, the first new-bank data appears 1 cycle later than without the macro.
- `DSC_SCHED_RDREG_EN` undefined:
  - `regData` is combinational from `regAddr`, with 0-cycle latency.
  - This matches the screen core's direct register-array read.

## Test plan
- Reset, then read all 32 addresses: `regData`=0 everywhere, `frame_cnt`=0, `wr_ready`=1, `commit_busy`=0.
- Write addr 3 = 0xDEADBEEF with no commit, then toggle vsync several frames: `regData`@3 stays 0 and `frame_cnt` counts frames.
- Write addr 3 = 0xDEADBEEF, pulse `commit_req`, then assert vsync:
  - `regData`@3 = 0xDEADBEEF from the next cycle (2 cycles with the macro)
  - `wr_ready`=0 for exactly 32 cycles
  - `commit_done` pulses once
- After that copy-back, write addr 5 = 0x1 and commit again: the new frame shows addr 3 = 0xDEADBEEF and addr 5 = 0x1, proving the copy-back preserved prior data.
- Hold `wr_valid` during COPY: no write lands until `wr_ready`=1. Also pulse `commit_req` during COPY: no second swap occurs.
- Assert `reset` at COPY cycle 10: all outputs return to their reset values. The next read of addr 3 gives 0, and `commit_done` never pulses.

Source files
------------

// File: rtl/dsc_reg_sched.sv
// dsc_reg_sched: double-buffered display register file with frame-aligned commit.
// Latency: CPU writes land in the shadow bank on the accepting edge; a commit
//          swaps banks at the next vsync edge, then a 2^AW-cycle copy-back follows.
// Backpressure: wr_ready drops for the whole copy-back; commit_req outside IDLE is dropped.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wr_valid/ready/addr/data  CPU write port into the shadow bank
//   commit_req            request a bank swap at the next frame boundary
//   commit_busy           commit pending or copy-back in progress
//   commit_done           one-cycle pulse after the last copy-back word
//   vsync                 screen vsync (already in clk domain), active level VS_POL
//   regAddr/regData       display read port on the active bank
//   frame_cnt             count of frame boundaries, wraps at 16 bits
//
// Build option: define DSC_SCHED_RDREG_EN to register regData (1-cycle read
// latency); otherwise regData is a combinational read of the active bank.
module dsc_reg_sched #(
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter bit VS_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          commit_req,
  output logic          commit_busy,
  output logic          commit_done,
  input  logic          vsync,
  input  logic [AW-1:0] regAddr,
  output logic [DW-1:0] regData,
  output logic [15:0]   frame_cnt
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_COPY = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          vsync_q;
  logic          sel_q, sel_d;
  logic [AW-1:0] cc_q, cc_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          commit_done_q, commit_done_d;

  // Bank storage. sel_q picks the active bank; the other one is the shadow.
  logic [DW-1:0] bank0_q [DEPTH];
  logic [DW-1:0] bank1_q [DEPTH];

  logic          fb;
  logic          wr_acc;
  logic          copy_last;
  logic          bank_we;
  logic [AW-1:0] bank_waddr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] act_rd;
  logic [DW-1:0] act_cc;

  // Frame boundary: first cycle vsync sits at its active level.
  assign fb        = (vsync == VS_POL) && (vsync_q != VS_POL);
  assign wr_acc    = wr_valid && wr_ready;
  assign copy_last = (cc_q == {AW{1'b1}});

  assign act_rd = sel_q ? bank1_q[regAddr] : bank0_q[regAddr];
  assign act_cc = sel_q ? bank1_q[cc_q]    : bank0_q[cc_q];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // A simultaneous fb is deliberately not taken: the swap waits a frame.
        if (commit_req) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (fb) begin
          state_d = ST_COPY;
        end
      end
      ST_COPY: begin
        if (copy_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready    = (state_q != ST_COPY);
    commit_busy = (state_q != ST_IDLE);
    commit_done = commit_done_q;
    frame_cnt   = frame_cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d         = sel_q;
    cc_d          = cc_q;
    frame_cnt_d   = frame_cnt_q;
    commit_done_d = 1'b0;

    if (fb) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end

    if ((state_q == ST_PEND) && fb) begin
      sel_d = ~sel_q;
      cc_d  = '0;
    end else if (state_q == ST_COPY) begin
      cc_d          = cc_q + {{(AW-1){1'b0}}, 1'b1};
      commit_done_d = copy_last;
    end
  end

  // Shadow write mux. CPU writes and copy-back never collide because the CPU
  // port is stalled for the whole COPY state.
  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = wr_addr;
    bank_wdata = wr_data;
    if (state_q == ST_COPY) begin
      bank_we    = 1'b1;
      bank_waddr = cc_q;
      bank_wdata = act_cc;
    end else if (wr_acc) begin
      bank_we = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q       <= ~VS_POL;
      sel_q         <= 1'b0;
      cc_q          <= '0;
      frame_cnt_q   <= '0;
      commit_done_q <= 1'b0;
    end else begin
      vsync_q       <= vsync;
      sel_q         <= sel_d;
      cc_q          <= cc_d;
      frame_cnt_q   <= frame_cnt_d;
      commit_done_q <= commit_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Banks. The shadow is chosen with the pre-edge sel_q, so a write in the same
  // cycle as the swapping fb lands in the bank that becomes active.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank0_q[i] <= '0;
      end
    end else if (bank_we && sel_q) begin
      bank0_q[bank_waddr] <= bank_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank1_q[i] <= '0;
      end
    end else if (bank_we && !sel_q) begin
      bank1_q[bank_waddr] <= bank_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Display read port
  // ---------------------------------------------------------------------------
`ifdef DSC_SCHED_RDREG_EN
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= act_rd;
    end
  end

  assign regData = rd_data_q;
`else
  assign regData = act_rd;
`endif

endmodule

// File: tb/tb_dsc_reg_sched.sv
// tb_dsc_reg_sched: directed table, hand sequences and randomized traffic for dsc_reg_sched.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 4ns after it.
// Backpressure: stalled writes are simply not applied in the reference model.
module tb_dsc_reg_sched;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int N      = 1 << AW;
  localparam bit VS_POL = 1'b0;
`ifdef DSC_SCHED_RDREG_EN
  localparam bit RDREG = 1'b1;
`else
  localparam bit RDREG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          commit_req;
  logic          commit_busy;
  logic          commit_done;
  logic          vsync;
  logic [AW-1:0] regAddr;
  logic [DW-1:0] regData;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  dsc_reg_sched #(.AW(AW), .DW(DW), .VS_POL(VS_POL)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .vsync       (vsync),
    .regAddr     (regAddr),
    .regData     (regData),
    .frame_cnt   (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the displayed bank and the CPU-visible bank as plain
  // arrays. A swap makes the CPU copy visible and, since the copy-back ends
  // with both banks equal and the shadow is unobservable meanwhile, simply
  // copies the whole array. A countdown stands in for the copy-back duration.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_act [N];
  logic [DW-1:0] m_shd [N];
  logic          m_pend;
  int            m_copy_left;
  logic          m_done;
  logic [15:0]   m_fcnt;
  logic          m_vs_prev;
  logic [DW-1:0] m_rdq;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = '0;
      m_shd[i] = '0;
    end
    m_pend      = 1'b0;
    m_copy_left = 0;
    m_done      = 1'b0;
    m_fcnt      = '0;
    m_vs_prev   = ~VS_POL;
    m_rdq       = '0;
  endtask

  task automatic model_update();
    logic          fb;
    logic [DW-1:0] rd_s;
    if (reset) begin
      model_reset();
      return;
    end
    fb     = (vsync == VS_POL) && (m_vs_prev != VS_POL);
    rd_s   = m_act[regAddr];
    m_done = (m_copy_left == 1);
    if (m_copy_left > 0) begin
      m_copy_left--;
    end else begin
      if (wr_valid) m_shd[wr_addr] = wr_data;
      if (m_pend) begin
        if (fb) begin
          m_act       = m_shd;
          m_pend      = 1'b0;
          m_copy_left = N;
        end
      end else if (commit_req) begin
        m_pend = 1'b1;
      end
    end
    if (fb) m_fcnt = m_fcnt + 16'd1;
    m_vs_prev = vsync;
    m_rdq     = rd_s;
  endtask

  function automatic logic [DW-1:0] m_rd();
    return RDREG ? m_rdq : m_act[regAddr];
  endfunction

  task automatic cmp_model();
    chk("mdl_wr_ready",    wr_ready,    m_copy_left == 0);
    chk("mdl_commit_busy", commit_busy, m_pend || (m_copy_left > 0));
    chk("mdl_commit_done", commit_done, m_done);
    chk("mdl_frame_cnt",   frame_cnt,   m_fcnt);
    chk("mdl_regData",     regData,     m_rd());
  endtask

  // One clock: inputs already driven at edge+1; compare at edge+4; advance.
  task automatic cycle();
    if (reset) model_reset();
    #3;
    cmp_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table (default read-port timing; rows flagged stab are
  // also valid with the registered read port).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          cr;
    logic          vs;
    logic [AW-1:0] ra;
    logic          rdy;
    logic          busy;
    logic          done;
    logic [DW-1:0] rd;
    logic [15:0]   fc;
    logic          stab;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int low;
    int dones;

    // write 3 without commit, frames pass, nothing visible
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0, 1'b1};
    vecs[1]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0, 1'b1};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0, 1'b1};
    vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd1, 1'b1};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd1, 1'b1};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd1, 1'b1};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd2, 1'b1};
    // commit, then fb in PEND swaps
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h0,        16'd2, 1'b1};
    vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0,        16'd2, 1'b1};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 32'h0,        16'd2, 1'b1};
    vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 16'd3, 1'b0};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 16'd3, 1'b1};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0,        16'd3, 1'b0};
    vecs[13] = '{1'b1, 5'd5, 32'h1,        1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 32'h0,        16'd3, 1'b1};

    // ---------------- reset state ----------------
    reset      = 1'b1;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    commit_req = 1'b0;
    vsync      = ~VS_POL;
    regAddr    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_ready",    wr_ready,    1'b1);
    chk("rst_commit_busy", commit_busy, 1'b0);
    chk("rst_commit_done", commit_done, 1'b0);
    chk("rst_frame_cnt",   frame_cnt,   16'd0);
    for (int i = 0; i < N; i++) begin
      regAddr = AW'(i);
      #1;
      chk("rst_regData", regData, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---------------- table ----------------
    for (int r = 0; r < 14; r++) begin
      wr_valid   = vecs[r].wv;
      wr_addr    = vecs[r].wa;
      wr_data    = vecs[r].wd;
      commit_req = vecs[r].cr;
      vsync      = vecs[r].vs;
      regAddr    = vecs[r].ra;
      #3;
      chk("tbl_wr_ready",    wr_ready,    vecs[r].rdy);
      chk("tbl_commit_busy", commit_busy, vecs[r].busy);
      chk("tbl_commit_done", commit_done, vecs[r].done);
      chk("tbl_frame_cnt",   frame_cnt,   vecs[r].fc);
      if (!RDREG || vecs[r].stab) chk("tbl_regData", regData, vecs[r].rd);
      @(posedge clk);
      model_update();
      #1;
    end

    // ---------------- held write + ignored commit during COPY ----------------
    // Table rows 10..13 were the first four COPY cycles.
    low        = 4;
    dones      = 0;
    commit_req = 1'b1;
    while (!wr_ready && low < 100) begin
      low++;
      cycle();
      commit_req = 1'b0;
      if (commit_done) dones++;
    end
    chk("copy_len", low, 32);
    chk("done_at_ready", commit_done, 1'b1);
    cycle();                 // held write accepted here
    wr_valid = 1'b0;
    repeat (3) begin
      cycle();
      if (commit_done) dones++;
    end
    chk("done_pulses", dones, 1);
    chk("no_second_swap", commit_busy, 1'b0);

    // ---------------- second commit shows preserved data ----------------
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
    vsync = ~VS_POL;
    cycle();
    vsync = VS_POL;
    cycle();
    for (int k = 0; k < 100 && !wr_ready; k++) cycle();
    chk("copy2_end", wr_ready, 1'b1);
    regAddr = 5'd3;
    cycle();
    cycle();
    chk("preserved_addr3", regData, 32'hDEADBEEF);
    regAddr = 5'd5;
    cycle();
    cycle();
    chk("new_addr5", regData, 32'h1);

    // ---------------- reset at COPY cycle 10 ----------------
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
    vsync = ~VS_POL;
    cycle();
    vsync = VS_POL;
    cycle();                 // fb edge: now COPY cycle 0
    repeat (10) cycle();
    regAddr = 5'd3;
    reset   = 1'b1;
    #1;
    chk("mid_rst_wr_ready",    wr_ready,    1'b1);
    chk("mid_rst_commit_busy", commit_busy, 1'b0);
    chk("mid_rst_commit_done", commit_done, 1'b0);
    chk("mid_rst_frame_cnt",   frame_cnt,   16'd0);
    chk("mid_rst_regData",     regData,     32'h0);
    cycle();
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      cycle();
      if (commit_done) dones++;
    end
    chk("rst_no_done", dones, 0);
    chk("rst_addr3", regData, 32'h0);

    // ---------------- randomized traffic ----------------
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 599) == 0);
      wr_valid   = $urandom_range(0, 1);
      wr_addr    = AW'($urandom_range(0, N - 1));
      wr_data    = $urandom;
      commit_req = ($urandom_range(0, 9) == 0);
      vsync      = ($urandom_range(0, 5) == 0) ? VS_POL : ~VS_POL;
      regAddr    = AW'($urandom_range(0, N - 1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
